// File: rtl/clk_div_n_if.sv
// rtl/clk_div_n_if.sv - control/status bundle for the programmable clock divider
//
// Signals:
//   en       run enable, sampled on posedge clk
//   div      requested divide ratio N (0 and 1 are treated as 2)
//   y        divided clock, 50 % duty
//   tick     one-clk pulse in the cycle after each period start
//   div_act  ratio of the period currently running (after clamping)
// Modports: master drives en/div, slave is the divider.

interface clk_div_n_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div;
    logic             y;
    logic             tick;
    logic [WIDTH-1:0] div_act;

    modport master (
        output en,
        output div,
        input  y,
        input  tick,
        input  div_act
    );

    modport slave (
        input  en,
        input  div,
        output y,
        output tick,
        output div_act
    );
endinterface

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - programmable integer clock divider, 50 % duty for odd and even N
//
// Ports:
//   clk   system clock; both edges are used
//   rst   asynchronous active-low reset
//   bus   clk_div_n_if.slave: en, div in; y, tick, div_act out
//
// A posedge counter produces the floor(N/2)-cycle high phase in q_pos_q. For odd
// N a negedge flop (q_neg_q) echoes q_pos_q half a cycle later, stretching the
// high phase by half a cycle. The ratio is latched only at a period start.

module clk_div_n #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    clk_div_n_if.slave  bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_act_q, n_act_d;
    logic             odd_act_q, odd_act_d;
    logic             started_q, started_d;
    logic             q_pos_q, q_pos_d;
    logic             tick_q, tick_d;
    logic             q_neg_q;

    logic [WIDTH-1:0] div_clamped;
    logic [WIDTH-1:0] half;
    logic [WIDTH-1:0] cnt_inc;
    logic             period_start;

    assign div_clamped  = (bus.div < WIDTH'(2)) ? WIDTH'(2) : bus.div;
    assign half         = n_act_q >> 1;
    assign cnt_inc      = cnt_q + WIDTH'(1);
    // cnt never passes n_act-1, so the increment cannot wrap.
    assign period_start = bus.en && (!started_q || (cnt_q == n_act_q - WIDTH'(1)));

    always_comb begin
        cnt_d     = cnt_q;
        n_act_d   = n_act_q;
        odd_act_d = odd_act_q;
        started_d = started_q;
        q_pos_d   = q_pos_q;
        tick_d    = 1'b0;
        if (!bus.en) begin
            // Ratio state holds so div_act stays meaningful while paused.
            cnt_d     = '0;
            q_pos_d   = 1'b0;
            started_d = 1'b0;
        end else if (period_start) begin
            n_act_d   = div_clamped;
            odd_act_d = div_clamped[0];
            cnt_d     = '0;
            q_pos_d   = 1'b1;
            tick_d    = 1'b1;
            started_d = 1'b1;
        end else begin
            cnt_d   = cnt_inc;
            q_pos_d = (cnt_inc < half);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            n_act_q   <= WIDTH'(2);
            odd_act_q <= 1'b0;
            started_q <= 1'b0;
            q_pos_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            n_act_q   <= n_act_d;
            odd_act_q <= odd_act_d;
            started_q <= started_d;
            q_pos_q   <= q_pos_d;
            tick_q    <= tick_d;
        end
    end

    // q_neg_q is still high at the posedge where q_pos_q falls, so the OR below
    // hands the high level over without a gap.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            q_neg_q <= 1'b0;
        end else begin
            q_neg_q <= q_pos_q & odd_act_q;
        end
    end

    assign bus.y       = q_pos_q | q_neg_q;
    assign bus.tick    = tick_q;
    assign bus.div_act = n_act_q;

endmodule

// File: doc/clk_div_n.md
# clk_div_n

Programmable integer clock divider with 50 % duty cycle for both odd and even ratios, and the parametrised successor to the fixed divide-by-3 block.
- A posedge counter generates the high phase. A negedge stretch flop adds the half cycle that odd ratios need.
- The ratio is taken from a runtime input and applied only at a period boundary, so the output never glitches or shortens a phase.
- It sits in the clock-generation area and drives slow-clock domains and strobes from the system clock.

## Interface
- WIDTH, default 8: width of the divisor input. Minimum 2. Maximum ratio is 2^WIDTH-1.
- clk  input  1  system clock. Both edges are used internally.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  run enable, sampled on posedge clk.
- div  input  WIDTH  requested divide ratio N. Values 0 and 1 are clamped to 2.
- y  output  1  divided clock, 50 % duty.
- tick  output  1  one-clk pulse, high in the cycle following each period start.
- div_act  output  WIDTH  ratio of the period currently running (after clamping).

## Operation
- Internal state: cnt (WIDTH bits), n_act (WIDTH bits), odd_act, started, q_pos (posedge flop) and q_neg (negedge flop).
- Output: y = q_pos | q_neg. Define H = floor(n_act/2). div_act = n_act.
- Period start happens on a posedge with en=1 when started=0 or cnt==n_act-1. On that edge:
  - n_act <= clamp(div), odd_act <= clamp(div)[0]
  - cnt <= 0, q_pos <= 1, tick <= 1, started <= 1
- Any other posedge with en=1:
  - cnt <= cnt+1, q_pos <= (cnt+1 < H), tick <= 0
  - div is ignored until the next period start.
- Posedge with en=0:
  - cnt <= 0, q_pos <= 0, tick <= 0, started <= 0
  - n_act and odd_act hold.
  - When en returns high, a new period starts on that edge.
- Negedge: q_neg <= q_pos & odd_act.
- Resulting waveform:
  - Even N: y is high N/2 cycles and low N/2 cycles.
  - Odd N: y is high (N-1)/2 + ½ cycles and low the same.
  - Examples: N=3 gives 1.5/1.5, N=5 gives 2.5/2.5, N=2 gives 1/1.
- Clamp rule: clamp(d) = 2 if d < 2, else d. Counter arithmetic is unsigned WIDTH-bit; cnt never exceeds n_act-1, so there is no wrap.

## Timing
- Reset asserted (rst=0), asynchronously and immediately:
  - cnt=0, n_act=2, odd_act=0, started=0
  - q_pos=0, q_neg=0, y=0, tick=0, div_act=2
- Reset mid-operation truncates the current period immediately, with y low.
- After release, the first posedge with en=1 starts a period: y rises after that edge and tick is high for that cycle.
- Latency:
  - div to effect: takes effect at the next period start, which is within at most the old n_act cycles.
  - en high to y rising: 1 posedge.
  - en low to y low: y is low after the next posedge if q_neg=0, otherwise after the following negedge.
- y transitions:
  - y rises only on posedge clk.
  - y falls on posedge (even N) or negedge (odd N).
  - y must not glitch at q_pos/q_neg overlap: q_neg stays high across the posedge where q_pos falls.
- Changing div every cycle is legal. Only the value sampled at the period-start edge matters.
- en and div are synchronous to clk. rst deassertion must be synchronised externally to posedge clk.

## Test plan
- Reset with div=3, en=1, clk period 10 ns:
  - y=0 and tick=0 during reset.
  - After release, y is high 15 ns and low 15 ns repeating.
  - tick pulses every 30 ns, div_act=3.
- Ratio sweep, checking each for at least 3 periods:
  - div=2: y 10/10 ns.
  - div=4: y 20/20 ns.
  - div=5: y 25/25 ns.
  - div=8: y 40/40 ns.
- Mid-period change: div=5 running, set div=6 at cnt=1.
  - The current period completes at 25/25 ns.
  - The next period is 30/30 ns.
  - div_act changes 5 to 6 exactly at the tick edge.
- Clamp: div=0 and div=1 each give y 10/10 ns with div_act=2.
- Enable: div=7, drop en at cnt=2 (y high).
  - y is low by the next negedge, cnt=0, tick stays 0.
  - Raising en restarts with a full 35 ns high phase.
- Async reset mid-period: div=9, assert rst between edges.
  - All outputs clear immediately with no clk edge.
  - After release, y restarts with a full 45 ns high phase.
